// File: rtl/uart_word_tx.sv
// uart_word_tx -- serialises one multi-byte word as back-to-back UART frames.
//
// Each accepted word is sent as NBYTES frames with no idle gap between them.
// Every frame is: start bit (0), 8 data bits LSB first, an optional parity
// bit, then STOP_BITS stop bits (1). Each bit lasts CLKS_PER_BIT clk cycles.
//
// Parameters:
//   CLKS_PER_BIT  clk cycles per serial bit (2..65535)
//   NBYTES        bytes per accepted word (1..8)
//   MSB_FIRST     1: most significant byte of in_data goes first, 0: byte 0 first
//   PARITY        0 none, 1 even, 2 odd
//   STOP_BITS     stop bits per byte (1 or 2)
//
// Ports:
//   clk       single clock, rising edge
//   reset     synchronous, active-high reset
//   in_valid  word offered
//   in_data   word to send (8*NBYTES bits), captured on the accept edge
//   in_ready  high exactly while idle; a word is accepted when in_valid && in_ready
//   tx        registered serial line, idle high
//   busy      inverse of in_ready
//   done      registered one-cycle pulse on the first idle cycle after a word

module uart_word_tx #(
  parameter int CLKS_PER_BIT = 234,
  parameter int NBYTES       = 4,
  parameter int MSB_FIRST    = 1,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  input  logic [8*NBYTES-1:0]   in_data,
  output logic                  in_ready,
  output logic                  tx,
  output logic                  busy,
  output logic                  done
);

  localparam int         W         = 8 * NBYTES;
  localparam logic [15:0] CNT_LAST  = 16'(CLKS_PER_BIT - 1);
  localparam logic [2:0]  BYTE_LAST = 3'(NBYTES - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP
  } state_t;

  state_t         state_q, state_d;
  logic [15:0]    cnt_q,   cnt_d;
  logic [2:0]     bit_q,   bit_d;
  logic [2:0]     byte_q,  byte_d;
  logic           stop_q,  stop_d;
  logic [W-1:0]   shreg_q, shreg_d;
  logic           tx_q,    tx_d;
  logic           done_q,  done_d;

  logic [W-1:0]   word_ordered;
  logic           bit_end;
  logic           par_bit;
  logic [2:0]     bit_next;

  // The shift register always holds the byte being sent in [7:0] and moves
  // down by one byte per frame, so MSB-first order is handled once here by
  // reversing the bytes at capture time.
  always_comb begin
    word_ordered = in_data;
    if (MSB_FIRST != 0) begin
      for (int i = 0; i < NBYTES; i++) begin
        word_ordered[8*i +: 8] = in_data[8*(NBYTES-1-i) +: 8];
      end
    end
  end

  assign bit_end  = (cnt_q == CNT_LAST);
  assign bit_next = bit_q + 3'd1;   // wraps 7 -> 0 at the end of a byte
  assign par_bit  = (PARITY == 2) ? ~(^shreg_q[7:0]) : (^shreg_q[7:0]);

  // tx_d is the value the line takes on the edge a new state or bit is
  // entered, which keeps tx a plain register with no output decode.
  always_comb begin
    // NOTE: every signal assigned below gets a default first, so no path
    // through the case can leave one unassigned and infer a latch.
    state_d = state_q;
    cnt_d   = '0;
    bit_d   = bit_q;
    byte_d  = byte_q;
    stop_d  = stop_q;
    shreg_d = shreg_q;
    tx_d    = tx_q;
    done_d  = 1'b0;

    // Bit-period counter runs 0..CLKS_PER_BIT-1 in every non-idle state.
    if (state_q != S_IDLE && !bit_end) begin
      cnt_d = cnt_q + 16'd1;
    end

    case (state_q)
      S_IDLE: begin
        tx_d = 1'b1;
        if (in_valid) begin
          state_d = S_START;
          tx_d    = 1'b0;
          bit_d   = '0;
          byte_d  = '0;
          stop_d  = 1'b0;
          shreg_d = word_ordered;
        end
      end

      S_START: begin
        if (bit_end) begin
          state_d = S_DATA;
          bit_d   = '0;
          tx_d    = shreg_q[0];
        end
      end

      S_DATA: begin
        if (bit_end) begin
          bit_d = bit_next;
          if (bit_q == 3'd7) begin
            if (PARITY != 0) begin
              state_d = S_PARITY;
              tx_d    = par_bit;
            end else begin
              state_d = S_STOP;
              tx_d    = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            tx_d = shreg_q[bit_next];
          end
        end
      end

      S_PARITY: begin
        if (bit_end) begin
          state_d = S_STOP;
          tx_d    = 1'b1;
          stop_d  = 1'b0;
        end
      end

      S_STOP: begin
        if (bit_end) begin
          if (STOP_BITS == 2 && !stop_q) begin
            stop_d = 1'b1;
          end else if (byte_q == BYTE_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end else begin
            // Next byte starts immediately: no idle gap inside a word.
            state_d = S_START;
            tx_d    = 1'b0;
            byte_d  = byte_q + 3'd1;
            shreg_d = shreg_q >> 8;
          end
        end
      end

      default: begin
        state_d = S_IDLE;
        tx_d    = 1'b1;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: the shift register is an ordinary flop vector, not a memory, so
    // it is cleared with the rest of the state on reset.
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      byte_q  <= '0;
      stop_q  <= 1'b0;
      shreg_q <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the values from
      // before this edge, independent of statement order.
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      byte_q  <= byte_d;
      stop_q  <= stop_d;
      shreg_q <= shreg_d;
      tx_q    <= tx_d;
      done_q  <= done_d;
    end
  end

  assign in_ready = (state_q == S_IDLE);
  assign busy     = ~in_ready;
  assign tx       = tx_q;
  assign done     = done_q;

endmodule
